// File: rtl/bridge_hs_buffer_pkg.sv
// Shared types and constants for the high-score window buffer.
// Imported by the interface, the register file and the top.
package bridge_hs_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } hs_state_e;

    localparam logic [31:0] HS_BASE_ADDR = 32'h1000_1620;
    localparam int HS_NUM_WORDS = 20;
    localparam int HS_IDX_W = $clog2(HS_NUM_WORDS);

    typedef logic [HS_IDX_W-1:0] hs_idx_t;

    function automatic logic hs_idx_ok(hs_idx_t idx);
        return 32'(idx) < 32'(HS_NUM_WORDS);
    endfunction

endpackage

// File: rtl/bridge_hs_buffer_if.sv
// Bridge and core access bundle for the high-score buffer.
// master drives requests, slave (the buffer) returns read data.
interface bridge_hs_buffer_if;
    import bridge_hs_buffer_pkg::*;

    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    hs_idx_t     core_idx;
    logic        core_wr;
    logic [3:0]  core_be;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;

    modport master (
        output bridge_addr,
        output bridge_wr,
        output bridge_wr_data,
        output bridge_rd,
        input  bridge_rd_data,
        output core_idx,
        output core_wr,
        output core_be,
        output core_wr_data,
        input  core_rd_data
    );

    modport slave (
        input  bridge_addr,
        input  bridge_wr,
        input  bridge_wr_data,
        input  bridge_rd,
        output bridge_rd_data,
        input  core_idx,
        input  core_wr,
        input  core_be,
        input  core_wr_data,
        output core_rd_data
    );

endinterface

// File: rtl/bridge_hs_buffer_hs_dpram.sv
// Two-port 32-bit register file holding the high-score image.
// Bridge port writes whole words and wins any same-word collision.
module hs_dpram
    import bridge_hs_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        br_wr,
    input  hs_idx_t     br_idx,
    input  logic [31:0] br_wr_data,
    input  logic        br_rd,
    input  logic        br_rd_ok,
    output logic [31:0] br_rd_data,
    input  logic        cr_wr,
    input  hs_idx_t     cr_idx,
    input  logic [3:0]  cr_be,
    input  logic [31:0] cr_wr_data,
    input  logic        cr_rd_ok,
    output logic [31:0] cr_rd_data,
    output logic        cr_wr_ok
);

    logic [31:0] mem_q [HS_NUM_WORDS];
    logic [31:0] mem_d [HS_NUM_WORDS];
    logic [31:0] br_rd_data_q;
    logic [31:0] br_rd_data_d;
    logic [31:0] cr_rd_data_q;
    logic [31:0] cr_rd_data_d;

    // Next image: bridge word first, core bytes only if no collision.
    always_comb begin
        mem_d = mem_q;
        cr_wr_ok = cr_wr && !(br_wr && (br_idx == cr_idx));
        if (br_wr) begin
            mem_d[br_idx] = br_wr_data;
        end
        if (cr_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cr_be[b]) begin
                    mem_d[cr_idx][8*b +: 8] = cr_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read ports sample the image as it stood before this edge.
    always_comb begin
        br_rd_data_d = br_rd_data_q;
        if (br_rd) begin
            br_rd_data_d = br_rd_ok ? mem_q[br_idx] : 32'h0;
        end
        cr_rd_data_d = cr_rd_ok ? mem_q[cr_idx] : 32'h0;
    end

    // Image storage survives reset; the host reloads it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_rd_data_q <= 32'h0;
            cr_rd_data_q <= 32'h0;
        end else begin
            br_rd_data_q <= br_rd_data_d;
            cr_rd_data_q <= cr_rd_data_d;
        end
    end

    assign br_rd_data = br_rd_data_q;
    assign cr_rd_data = cr_rd_data_q;

endmodule

// File: rtl/bridge_hs_buffer.sv
// High-score window leaf: address decode, dirty tracking and
// a save request raised once per menu entry until acknowledged.
module bridge_hs_buffer
    import bridge_hs_buffer_pkg::*;
(
    input  logic             clk_74a,
    input  logic             reset,
    bridge_hs_buffer_if.slave bus,
    input  logic             in_menu,
    output logic             save_req,
    input  logic             save_ack,
    output logic             dirty
);

    logic [31:0] br_off;
    logic [31:0] br_word;
    hs_idx_t     br_idx;
    logic        br_ok;
    logic        br_wr;
    logic        cr_ok;
    logic        cr_wr;
    logic        cr_wr_ok;
    logic        ack_hit;
    logic        dirty_q;
    logic        dirty_d;
    logic        in_menu_q;
    logic        in_menu_d;
    logic        save_req_q;
    hs_state_e   state_q;

    // Byte address to word index, with range check on both ports.
    always_comb begin
        br_off  = bus.bridge_addr - HS_BASE_ADDR;
        br_word = br_off >> 2;
        br_ok   = br_word < 32'(HS_NUM_WORDS);
        br_idx  = br_word[HS_IDX_W-1:0];
        br_wr   = bus.bridge_wr && br_ok;
        cr_ok   = hs_idx_ok(bus.core_idx);
        cr_wr   = bus.core_wr && cr_ok;
    end

    hs_dpram u_dpram (
        .clk        (clk_74a),
        .reset      (reset),
        .br_wr      (br_wr),
        .br_idx     (br_idx),
        .br_wr_data (bus.bridge_wr_data),
        .br_rd      (bus.bridge_rd),
        .br_rd_ok   (br_ok),
        .br_rd_data (bus.bridge_rd_data),
        .cr_wr      (cr_wr),
        .cr_idx     (bus.core_idx),
        .cr_be      (bus.core_be),
        .cr_wr_data (bus.core_wr_data),
        .cr_rd_ok   (cr_ok),
        .cr_rd_data (bus.core_rd_data),
        .cr_wr_ok   (cr_wr_ok)
    );

    // Core edits set dirty; host load or save ack clears it.
    always_comb begin
        ack_hit   = (state_q == REQ) && save_ack;
        in_menu_d = in_menu;
        dirty_d   = dirty_q;
        if (cr_wr_ok) begin
            dirty_d = 1'b1;
        end else if (br_wr || ack_hit) begin
            dirty_d = 1'b0;
        end
    end

    // Dirty flag and menu edge register.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            dirty_q   <= 1'b0;
            in_menu_q <= 1'b0;
        end else begin
            dirty_q   <= dirty_d;
            in_menu_q <= in_menu_d;
        end
    end

    // Save FSM: request on menu entry, hold until menu closes.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_q    <= IDLE;
            save_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_menu && !in_menu_q && dirty_q) begin
                        state_q    <= REQ;
                        save_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (save_ack) begin
                        state_q    <= HOLD;
                        save_req_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!in_menu) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    save_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign save_req = save_req_q;
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_bridge_hs_buffer.sv
// Scoreboard bench for bridge_hs_buffer: directed cases then
// random traffic checked against a word-array reference model.
module tb_bridge_hs_buffer;
    import bridge_hs_buffer_pkg::*;

    localparam logic [31:0] B = 32'h1000_1620;

    logic clk = 1'b0;
    logic rst;
    logic in_menu;
    logic save_req;
    logic save_ack;
    logic dirty;

    always #5 clk = ~clk;

    bridge_hs_buffer_if bus ();

    bridge_hs_buffer dut (
        .clk_74a  (clk),
        .reset    (rst),
        .bus      (bus),
        .in_menu  (in_menu),
        .save_req (save_req),
        .save_ack (save_ack),
        .dirty    (dirty)
    );

    typedef struct {
        logic [31:0] brd;
        bit          brd_k;
        logic [31:0] crd;
        bit          crd_k;
        bit          dirty;
        bit          req;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m_mem [20];
    bit          m_val [20];
    logic [31:0] m_brd = 32'h0;
    bit          m_brd_k = 1'b0;
    bit          m_dirty = 1'b0;
    bit          m_req = 1'b0;
    bit          m_served = 1'b0;
    bit          m_prev = 1'b0;

    logic        s_rst = 1'b1;
    logic [31:0] s_addr = B;
    logic        s_bwr = 1'b0;
    logic [31:0] s_bwd = 32'h0;
    logic        s_brd = 1'b0;
    logic [4:0]  s_cidx = 5'd0;
    logic        s_cwr = 1'b0;
    logic [3:0]  s_be = 4'h0;
    logic [31:0] s_cwd = 32'h0;
    logic        s_menu = 1'b0;
    logic        s_ack = 1'b0;

    initial begin
        for (int i = 0; i < 20; i++) m_val[i] = 1'b0;
    end

    // One clock of stimulus plus the model's view of the next edge.
    task automatic step();
        exp_t        e;
        logic [31:0] off;
        int          bi;
        int          ci;
        bit          bok;
        bit          bw;
        bit          cw;
        bit          ack_hit;
        @(negedge clk);
        rst = s_rst;
        bus.bridge_addr = s_addr;
        bus.bridge_wr = s_bwr;
        bus.bridge_wr_data = s_bwd;
        bus.bridge_rd = s_brd;
        bus.core_idx = s_cidx;
        bus.core_wr = s_cwr;
        bus.core_be = s_be;
        bus.core_wr_data = s_cwd;
        in_menu = s_menu;
        save_ack = s_ack;
        off = s_addr - B;
        bok = (off / 4) < 20;
        bi = bok ? int'(off / 4) : 0;
        ci = int'(s_cidx);
        if (s_rst) begin
            m_brd = 32'h0;
            m_brd_k = 1'b1;
            e.crd = 32'h0;
            e.crd_k = 1'b1;
            m_dirty = 1'b0;
            m_req = 1'b0;
            m_served = 1'b0;
            m_prev = 1'b0;
        end else begin
            if (s_brd) begin
                m_brd = bok ? m_mem[bi] : 32'h0;
                m_brd_k = bok ? m_val[bi] : 1'b1;
            end
            e.crd = (ci < 20) ? m_mem[ci] : 32'h0;
            e.crd_k = (ci < 20) ? m_val[ci] : 1'b1;
            bw = s_bwr && bok;
            cw = s_cwr && ci < 20 && !(bw && bi == ci);
            ack_hit = m_req && s_ack;
            if (m_req) begin
                if (s_ack) begin
                    m_req = 1'b0;
                    m_served = 1'b1;
                end
            end else if (m_served) begin
                if (!s_menu) m_served = 1'b0;
            end else if (s_menu && !m_prev && m_dirty) begin
                m_req = 1'b1;
            end
            if (cw) m_dirty = 1'b1;
            else if (bw || ack_hit) m_dirty = 1'b0;
            if (bw) begin
                m_mem[bi] = s_bwd;
                m_val[bi] = 1'b1;
            end
            if (cw) begin
                for (int b = 0; b < 4; b++)
                    if (s_be[b]) m_mem[ci][8*b +: 8] = s_cwd[8*b +: 8];
            end
            m_prev = s_menu;
        end
        e.brd = m_brd;
        e.brd_k = m_brd_k;
        e.dirty = m_dirty;
        e.req = m_req;
        q.push_back(e);
        s_bwr = 1'b0;
        s_brd = 1'b0;
        s_cwr = 1'b0;
        s_ack = 1'b0;
    endtask

    task automatic bwrite(input logic [31:0] a, input logic [31:0] d);
        s_addr = a;
        s_bwd = d;
        s_bwr = 1'b1;
        step();
    endtask

    task automatic bread(input logic [31:0] a);
        s_addr = a;
        s_brd = 1'b1;
        step();
    endtask

    task automatic cwrite(input logic [4:0] i, input logic [3:0] be,
                          input logic [31:0] d);
        s_cidx = i;
        s_be = be;
        s_cwd = d;
        s_cwr = 1'b1;
        step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every registered output after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (e.brd_k && bus.bridge_rd_data !== e.brd) begin
                    n_err++;
                    $display("FAIL sb_brd: got %h expected %h",
                             bus.bridge_rd_data, e.brd);
                end
                if (e.crd_k && bus.core_rd_data !== e.crd) begin
                    n_err++;
                    $display("FAIL sb_crd: got %h expected %h",
                             bus.core_rd_data, e.crd);
                end
                if (dirty !== e.dirty) begin
                    n_err++;
                    $display("FAIL sb_dirty: got %b expected %b",
                             dirty, e.dirty);
                end
                if (save_req !== e.req) begin
                    n_err++;
                    $display("FAIL sb_req: got %b expected %b",
                             save_req, e.req);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        s_rst = 1'b1;
        repeat (3) step();
        s_rst = 1'b0;
        step();
        chk("rst_brd", bus.bridge_rd_data, 32'h0);
        chk("rst_crd", bus.core_rd_data, 32'h0);
        chk("rst_req", 32'(save_req), 32'h0);
        chk("rst_dirty", 32'(dirty), 32'h0);

        for (int i = 0; i < 20; i++)
            bwrite(B + 32'(i * 4), 32'hA500_0000 | 32'(i));

        bwrite(32'h1000_1624, 32'hDEAD_BEEF);
        bread(32'h1000_1624);
        step();
        chk("t1_rd", bus.bridge_rd_data, 32'hDEAD_BEEF);
        chk("t1_dirty", 32'(dirty), 32'h0);

        cwrite(5'd1, 4'b0011, 32'h1234_5678);
        step();
        step();
        chk("t2_crd", bus.core_rd_data, 32'hDEAD_5678);
        chk("t2_dirty", 32'(dirty), 32'h1);

        s_menu = 1'b1;
        step();
        step();
        chk("t3_req", 32'(save_req), 32'h1);
        s_ack = 1'b1;
        step();
        step();
        chk("t3_req_off", 32'(save_req), 32'h0);
        chk("t3_dirty", 32'(dirty), 32'h0);
        repeat (5) step();
        chk("t3_no_rereq", 32'(save_req), 32'h0);
        s_menu = 1'b0;
        repeat (2) step();

        s_cidx = 5'd3;
        s_be = 4'hF;
        s_cwd = 32'h5555_5555;
        s_cwr = 1'b1;
        bwrite(32'h1000_162C, 32'hAAAA_AAAA);
        bread(32'h1000_162C);
        step();
        chk("t4_word3", bus.bridge_rd_data, 32'hAAAA_AAAA);
        chk("t4_dirty", 32'(dirty), 32'h0);

        bread(32'h1000_166C);
        step();
        chk("t5_last", bus.bridge_rd_data, 32'hA500_0013);
        bwrite(32'h1000_1670, 32'h0000_0077);
        bread(32'h1000_1670);
        step();
        chk("t5_oor_rd", bus.bridge_rd_data, 32'h0);
        s_cidx = 5'd20;
        step();
        step();
        chk("t5_oor_crd", bus.core_rd_data, 32'h0);

        cwrite(5'd7, 4'hF, 32'h0BAD_F00D);
        s_menu = 1'b1;
        step();
        step();
        chk("t6_req", 32'(save_req), 32'h1);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        step();
        chk("t6_req", 32'(save_req), 32'h0);
        chk("t6_dirty", 32'(dirty), 32'h0);
        chk("t6_brd", bus.bridge_rd_data, 32'h0);
        chk("t6_crd", bus.core_rd_data, 32'h0);
        s_menu = 1'b0;
        bread(32'h1000_1624);
        step();
        chk("t6_keep1", bus.bridge_rd_data, 32'hDEAD_5678);
        bread(32'h1000_163C);
        step();
        chk("t6_keep7", bus.bridge_rd_data, 32'h0BAD_F00D);

        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 399) == 0);
            w = $urandom_range(0, 23);
            s_addr = B + 32'(w * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) s_addr = B - 32'd4;
            s_bwd = $urandom;
            s_cidx = ($urandom_range(0, 7) == 0) ? 5'(w)
                   : 5'($urandom_range(0, 23));
            s_be = 4'($urandom);
            s_cwd = $urandom;
            if (!s_rst) begin
                s_bwr = ($urandom_range(0, 3) == 0);
                s_brd = ($urandom_range(0, 2) == 0);
                s_cwr = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 19) == 0) s_menu = ~s_menu;
            s_ack = ($urandom_range(0, 4) == 0);
            step();
        end
        s_rst = 1'b0;
        step();
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
